// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared types and line-level constants for the UART transmitter.
//            Holds the serializer state encoding and the idle/start/stop
//            levels driven onto the TX pin.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Serializer states. PARITY is only reachable when UART_TX_PARITY_EN
    // is defined; the encoding is kept fixed so both builds share it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Line levels (mark = 1)
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_core_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core_if
// Purpose  : Producer-side bundle of the UART transmitter: the start strobe
//            and parallel byte going in, the serial line and ready flag
//            coming out.
// Ports    : start - request to send (producer -> core)
//            data  - DATA_BITS payload (producer -> core)
//            q     - serial output, idle = 1 (core -> pin/producer)
//            ready - core idle, next start accepted (core -> producer)
// Modports : master (producer), slave (core)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 q;
    logic                 ready;

    modport master (
        output start,
        output data,
        input  q,
        input  ready
    );

    modport slave (
        input  start,
        input  data,
        output q,
        output ready
    );
endinterface : uart_tx_core_if
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and
//            raises bit_done during the last cycle of every bit period.
//            A synchronous clear realigns the count to the frame start.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset
//            clr      - synchronous clear of the count
//            en       - count enable (a frame is in flight)
//            bit_done - 1 in the final cycle of the current bit period
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      bit_done
);

    generate
        if (CLKS_PER_BIT <= 1) begin : g_single
            // Every enabled cycle is the last cycle of its bit: no counter.
            logic w_unused_inputs;
            assign w_unused_inputs = &{1'b0, clk, rst, clr};
            assign bit_done        = en;
        end else begin : g_count
            localparam int CW = $clog2(CLKS_PER_BIT);
            localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CW'(1);
                end
            end

            assign bit_done = en && (r_cnt == c_last);
        end
    endgenerate

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core
// Purpose  : UART transmit serializer. Accepts a parallel word on a start
//            strobe while ready and shifts it out LSB first as an
//            asynchronous frame: start bit, DATA_BITS data bits, optional
//            even parity bit, one stop bit. q and ready are registered.
// Ports    : clk - clock, all logic on posedge
//            rst - synchronous active-high reset (aborts a frame in flight)
//            bus - uart_tx_core_if.slave (start, data in; q, ready out)
// Config   : UART_TX_PARITY_EN - when defined, an even-parity bit is sent
//            between the last data bit and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_tx_core_if.slave   bus
);

    localparam int BCW = count_width(DATA_BITS);
    localparam logic [BCW-1:0] c_last_bit = BCW'(DATA_BITS);

    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [BCW-1:0]       r_bit_cnt;     // data bits already placed on q
    logic [BCW-1:0]       w_bit_cnt_next;
    logic                 r_q;
    logic                 w_q_next;
    logic                 r_ready;
    logic                 w_ready_next;
    logic                 w_accept;
    logic                 w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_parity_next;
`endif

    assign w_accept = (r_state == IDLE) && bus.start;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .en       (r_state != IDLE),
        .bit_done (w_bit_done)
    );

    // Next-state and next-output logic. q and ready are computed for the
    // state being entered, so the registered outputs change on the same
    // edge as the state register.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_q_next       = r_q;
        w_ready_next   = r_ready;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_q_next     = IDLE_LEVEL;
                w_ready_next = 1'b1;
                if (bus.start) begin
                    w_state_next   = START;
                    w_shift_next   = bus.data;
                    w_bit_cnt_next = '0;
                    w_q_next       = START_LEVEL;
                    w_ready_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity_next  = ^bus.data;
`endif
                end
            end

            START: begin
                if (w_bit_done) begin
                    // First data bit goes out; the register pre-shifts so
                    // that shift[0] always holds the next bit to send.
                    w_state_next   = DATA;
                    w_q_next       = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = BCW'(1);
                end
            end

            DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_q_next     = r_parity;
`else
                        w_state_next = STOP;
                        w_q_next     = STOP_LEVEL;
`endif
                    end else begin
                        w_q_next       = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = r_bit_cnt + BCW'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                    w_q_next     = STOP_LEVEL;
                end
            end
`endif

            STOP: begin
                if (w_bit_done) begin
                    w_state_next = IDLE;
                    w_q_next     = IDLE_LEVEL;
                    w_ready_next = 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_q_next     = IDLE_LEVEL;
                w_ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_q       <= IDLE_LEVEL;
            r_ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_q       <= w_q_next;
            r_ready   <= w_ready_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign bus.q     = r_q;
    assign bus.ready = r_ready;

endmodule : uart_tx_core
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_core
// Purpose  : Directed self-checking bench for uart_tx_core. Two instances
//            share clk/rst: dut_a at CLKS_PER_BIT=1, dut_b at CLKS_PER_BIT=4.
//            Frame expectations follow UART_TX_PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_core_if #(.DATA_BITS(8)) ifa ();
    uart_tx_core_if #(.DATA_BITS(8)) ifb ();

    uart_tx_core #(
        .CLKS_PER_BIT (1),
        .DATA_BITS    (8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    uart_tx_core #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks one complete frame. Entered #1 after the accepting edge; leaves
    // #1 after the edge that returns the DUT to idle, having checked ready=1.
    // inject_at >= 0 pulses a start with data 8'h2B at that frame cycle.
    task automatic run_frame(input int which, input int cpb, input logic [7:0] d,
                             input int inject_at, input string tag);
        logic exp_bits [0:10];
        int   nb;
        logic obs_q;
        logic obs_r;
        exp_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_bits[k+1] = d[k];
`ifdef UART_TX_PARITY_EN
        nb           = 11;
        exp_bits[9]  = ^d;
        exp_bits[10] = 1'b1;
`else
        nb           = 10;
        exp_bits[9]  = 1'b1;
        exp_bits[10] = 1'b1;
`endif
        for (int c = 0; c < nb * cpb; c++) begin
            if (inject_at >= 0 && c == inject_at) begin
                ifa.start = 1'b1;
                ifa.data  = 8'h2B;
            end else if (inject_at >= 0 && c == inject_at + 1) begin
                ifa.start = 1'b0;
            end
            obs_q = (which == 1) ? ifb.q : ifa.q;
            obs_r = (which == 1) ? ifb.ready : ifa.ready;
            chk($sformatf("%s q[%0d]", tag, c), obs_q, exp_bits[c / cpb]);
            chk($sformatf("%s ready[%0d]", tag, c), obs_r, 1'b0);
            tick();
        end
        obs_q = (which == 1) ? ifb.q : ifa.q;
        obs_r = (which == 1) ? ifb.ready : ifa.ready;
        chk({tag, " end q"}, obs_q, 1'b1);
        chk({tag, " end ready"}, obs_r, 1'b1);
    endtask

    task automatic idle_checks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s idle q[%0d]", tag, i), ifa.q, 1'b1);
            chk($sformatf("%s idle ready[%0d]", tag, i), ifa.ready, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] d;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        ifa.start = 1'b0;
        ifa.data  = 8'h00;
        ifb.start = 1'b0;
        ifb.data  = 8'h00;

        // Reset: 100 ns
        repeat (10) @(posedge clk);
        #1;
        chk("reset a q", ifa.q, 1'b1);
        chk("reset a ready", ifa.ready, 1'b1);
        chk("reset b q", ifb.q, 1'b1);
        chk("reset b ready", ifb.ready, 1'b1);
        rst = 1'b0;
        tick();
        chk("post-reset q", ifa.q, 1'b1);

        // 8'h5A: frame 0,0,1,0,1,1,0,1,0,1
        ifa.data  = 8'h5A;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.data  = 8'hFF;   // must not affect the frame in flight
        run_frame(0, 1, 8'h5A, -1, "f5A");
        idle_checks(2, "f5A");

        // Back-to-back with start held high: 8'h00 then 8'hFF
        ifa.data  = 8'h00;
        ifa.start = 1'b1;
        tick();
        ifa.data  = 8'hFF;
        run_frame(0, 1, 8'h00, -1, "f00");
        tick();              // start still high: accepted after one idle cycle
        ifa.start = 1'b0;
        ifa.data  = 8'h00;
        run_frame(0, 1, 8'hFF, -1, "fFF");
        idle_checks(2, "fFF");

        // start pulsed mid-frame with 8'h2B is ignored
        ifa.data  = 8'h96;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        run_frame(0, 1, 8'h96, 4, "f96");
        idle_checks(12, "f96");

        // Reset during data bit 4 of 8'h1C
        d         = 8'h1C;
        ifa.data  = d;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("f1C pre q[%0d]", c), ifa.q, (c == 0) ? 1'b0 : d[c-1]);
            tick();
        end
        chk("f1C bit4 q", ifa.q, d[4]);
        chk("f1C bit4 ready", ifa.ready, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort q", ifa.q, 1'b1);
        chk("abort ready", ifa.ready, 1'b1);
        rst = 1'b0;
        idle_checks(4, "abort");
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        run_frame(0, 1, 8'h1C, -1, "f1C");

        // 8'h13 (three ones): parity bit 1 when parity is enabled
        ifa.data  = 8'h13;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        run_frame(0, 1, 8'h13, -1, "f13");

        // CLKS_PER_BIT=4, 8'h81
        ifb.data  = 8'h81;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        ifb.data  = 8'h00;
        run_frame(1, 4, 8'h81, -1, "b81");
        tick();
        chk("b81 idle q", ifb.q, 1'b1);
        chk("b81 idle ready", ifb.ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_core
`default_nettype wire
